// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer used as a pipeline stage register.
// Head register drives out_*; the skid register catches one entry when the
// downstream stalls, so in_ready can be fully registered (no path from
// out_ready to in_ready).
module pipe_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state;
    logic                skid_valid;
    logic [DATA_W-1:0]   skid_data;
    logic [CTRL_W-1:0]   skid_ctrl;
    logic                in_fire;

    // in_ready is a register, so this accept term has no out_ready dependence
    assign in_fire = in_valid & in_ready;

    // State, head/skid registers and registered handshake outputs
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
            count      <= 2'd0;
            in_ready   <= 1'b1;
        end else if (Flush) begin
            // out_data keeps its last value; only control is forced to a bubble
            state      <= EMPTY;
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
            count      <= 2'd0;
            in_ready   <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        out_ctrl  <= in_ctrl;
                        state     <= ONE;
                        count     <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_fire && out_ready) begin
                        out_data <= in_data;
                        out_ctrl <= in_ctrl;
                    end else if (in_fire) begin
                        skid_valid <= 1'b1;
                        skid_data  <= in_data;
                        skid_ctrl  <= in_ctrl;
                        state      <= FULL;
                        count      <= 2'd2;
                        in_ready   <= 1'b0;
                    end else if (out_ready) begin
                        // head drains to a bubble: clear control, hold data
                        out_valid <= 1'b0;
                        out_ctrl  <= '0;
                        state     <= EMPTY;
                        count     <= 2'd0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        out_data   <= skid_data;
                        out_ctrl   <= skid_ctrl;
                        skid_valid <= 1'b0;
                        state      <= ONE;
                        count      <= 2'd1;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    out_valid  <= 1'b0;
                    out_ctrl   <= '0;
                    skid_valid <= 1'b0;
                    count      <= 2'd0;
                    in_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the datapath payload width (ALU result, read data, HI/LO and similar fields, concatenated by the instantiating stage).
REQ-002 Parameter CTRL_W, default 8, SHALL set the control payload width (RegWrite, MemtoReg and similar bits, plus func/dest fields).
REQ-003 Clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Clr  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-005 Flush  input  1  SHALL discard all held entries; it is synchronous and active-high.
REQ-006 in_valid  input  1  SHALL indicate that the upstream stage presents an entry.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts an entry this cycle.
REQ-008 in_data  input  DATA_W  SHALL carry the upstream datapath payload.
REQ-009 in_ctrl  input  CTRL_W  SHALL carry the upstream control payload.
REQ-010 out_valid  output  1  SHALL indicate that the head entry is presented downstream.
REQ-011 out_ready  input  1  SHALL indicate that the downstream stage consumes the head entry this cycle.
REQ-012 out_data  output  DATA_W  SHALL carry the head datapath payload.
REQ-013 out_ctrl  output  CTRL_W  SHALL carry the head control payload.
REQ-014 count  output  2  SHALL report occupancy (0, 1 or 2).

Function
REQ-015 The block SHALL be a 2-entry skid buffer: a head register driving out_* and a skid register, each with a valid bit.
REQ-016 States SHALL be EMPTY (count=0), ONE (count=1) and FULL (count=2).
REQ-017 A transfer SHALL occur on a port only when valid and ready are both high in the same cycle.
REQ-018 in_ready SHALL be a registered signal equal to (state != FULL); it SHALL have no combinational path from out_ready.
REQ-019 EMPTY: on an in transfer, load the head and go to ONE.
REQ-020 ONE, in transfer with out_ready=1: replace the head with the input and stay in ONE (full throughput, one entry per cycle).
REQ-021 ONE, in transfer with out_ready=0: load the skid and go to FULL.
REQ-022 ONE, no in transfer, out_ready=1: go to EMPTY.
REQ-023 FULL: on out_ready=1, move skid to head and go to ONE; no input SHALL be accepted in FULL.
REQ-024 Latency SHALL be 1 cycle: an entry accepted at edge N appears on out_* after edge N, with out_valid=1.
REQ-025 Order SHALL be strictly FIFO; no entry SHALL be dropped or duplicated except on Flush or Clr.
REQ-026 out_ctrl SHALL read all-zero whenever out_valid=0 (bubble), so write enables are never asserted by an empty stage.
REQ-027 out_data SHALL hold its last value while out_valid=0 or while stalled with out_ready=0.
REQ-028 Flush SHALL clear both valid bits and go to EMPTY; an input presented in the same cycle SHALL be dropped.
REQ-029 Priority SHALL be Clr > Flush > handshake.
REQ-030 count SHALL equal the sum of the head and skid valid bits, updated on the same edge as the state.

Reset
REQ-031 On Clr=1 at a rising edge, the block SHALL set state=EMPTY, out_valid=0, out_data=0, out_ctrl=0, count=0 and in_ready=1 after that edge.
REQ-032 Clr asserted mid-transfer SHALL discard both entries; no output SHALL appear until a new in transfer occurs after Clr is deasserted.

Verification
REQ-033 Clr, then in_valid=1, in_data=0xA5, in_ctrl=0x03, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0xA5, out_ctrl=0x03, count=1.
REQ-034 Continuous stream 1,2,3,4 with out_ready=1 -> outputs 1,2,3,4 on consecutive cycles; in_ready stays 1.
REQ-035 Send 0x11 then 0x22 with out_ready=0 -> count=2, in_ready=0, head=0x11; raise out_ready -> 0x11 then 0x22 emitted, count returns to 0.
REQ-036 In FULL, assert Flush together with in_valid=1 and in_data=0x33 -> next cycle count=0, out_valid=0, out_ctrl=0; 0x33 is never emitted.
REQ-037 Clr and Flush asserted together while count=1 -> reset values per REQ-031.
REQ-038 Random valid/ready stress (10k cycles, DATA_W=64, CTRL_W=4) against a scoreboard -> no loss, duplication or reordering, and count never exceeds 2.
